// File: rtl/jt900h_pkg.sv
// Shared definitions for the jt900h op-code prefetch path:
// default widths and the fetch controller state encodings.
package jt900h_pkg;

  localparam int JT_AW     = 24;
  localparam int JT_QDEPTH = 8;

  typedef logic [1:0] fetch_state_t;

  // IDLE: free to start a read; WAIT: read outstanding; DROP: discard a stale reply
  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_WAIT = 2'd1;
  localparam fetch_state_t ST_DROP = 2'd2;

endpackage

// File: rtl/jt900h_opfetch_fifo.sv
// Byte FIFO for the prefetch queue: up to two bytes written per cycle,
// a four-byte read window at the head and a 0-3 byte variable pop.
module jt900h_opfetch_fifo #(
  parameter int QDEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cen,
  input  logic                     i_flush,
  input  logic [1:0]               i_wrN,
  input  logic [7:0]               i_wrB0,
  input  logic [7:0]               i_wrB1,
  input  logic [1:0]               i_pop,
  output logic [31:0]              o_win,
  output logic [$clog2(QDEPTH):0]  o_count,
  output logic                     o_ok
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [QDEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  // Storage and pointers; a flush empties the queue and drops any write in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
    end else if (i_cen) begin
      if (i_flush) begin
        r_rd    <= '0;
        r_wr    <= '0;
        r_count <= '0;
      end else begin
        if (i_wrN != 2'd0) r_mem[r_wr] <= i_wrB0;
        if (i_wrN == 2'd2) r_mem[r_wr + PW'(1)] <= i_wrB1;
        r_wr    <= r_wr + PW'(i_wrN);
        r_rd    <= r_rd + PW'(i_pop);
        r_count <= r_count + CW'(i_wrN) - CW'(i_pop);
      end
    end
  end

  // Little-endian window of the four oldest bytes, read straight from registers
  always_comb begin
    o_win = '0;
    for (int k = 0; k < 4; k++) o_win[8*k +: 8] = r_mem[r_rd + PW'(k)];
  end

  assign o_count = r_count;
  assign o_ok    = (r_count >= CW'(4));

endmodule

// File: rtl/jt900h_opfetch.sv
// Instruction prefetch queue: fetches 16-bit words into a byte FIFO and
// presents the next four op-code bytes to the decoder, handling jumps
// to odd addresses and reads that are still in flight when a jump lands.
module jt900h_opfetch
  import jt900h_pkg::*;
#(
  parameter int QDEPTH = JT_QDEPTH,
  parameter int AW     = JT_AW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cen,
  input  logic          i_pc_load,
  input  logic [AW-1:0] i_pc_new,
  output logic [AW-1:0] o_pc,
  output logic [31:0]   o_op,
  output logic          o_op_ok,
  input  logic [1:0]    i_fetched,
  output logic [AW-1:0] o_bus_addr,
  output logic          o_bus_rd,
  input  logic [15:0]   i_bus_din,
  input  logic          i_bus_ok
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  r_state;
  logic [AW-1:0] r_pc;
  logic [AW-2:0] r_wordAddr;
  logic          r_skipLo;

  logic [CW-1:0] w_count;
  logic          w_canReq;
  logic          w_take;
  logic [1:0]    w_consumed;
  logic [1:0]    w_wrN;
  logic [7:0]    w_wrB0;

  assign w_canReq   = (w_count <= CW'(QDEPTH - 2));
  assign w_take     = (r_state == ST_WAIT) && i_bus_ok;
  assign w_consumed = o_op_ok ? i_fetched : 2'd0;
  assign w_wrN      = (w_take && !i_pc_load) ? (r_skipLo ? 2'd1 : 2'd2) : 2'd0;
  assign w_wrB0     = r_skipLo ? i_bus_din[15:8] : i_bus_din[7:0];

  jt900h_opfetch_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_cen   (i_cen),
    .i_flush (i_pc_load),
    .i_wrN   (w_wrN),
    .i_wrB0  (w_wrB0),
    .i_wrB1  (i_bus_din[15:8]),
    .i_pop   (w_consumed),
    .o_win   (o_op),
    .o_count (w_count),
    .o_ok    (o_op_ok)
  );

  // Fetch controller, pc tracking and jump handling; a jump beats every other event
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_wordAddr <= '0;
      r_skipLo   <= 1'b0;
    end else if (i_cen) begin
      if (i_pc_load) begin
        r_pc       <= i_pc_new;
        r_wordAddr <= i_pc_new[AW-1:1];
        r_skipLo   <= i_pc_new[0];
        r_state    <= ((r_state != ST_IDLE) && !i_bus_ok) ? ST_DROP : ST_IDLE;
      end else begin
        r_pc <= r_pc + AW'(w_consumed);
        case (r_state)
          ST_IDLE: if (w_canReq) r_state <= ST_WAIT;
          ST_WAIT: begin
            if (i_bus_ok) begin
              r_state    <= ST_IDLE;
              r_wordAddr <= r_wordAddr + 1'b1;
              r_skipLo   <= 1'b0;
            end
          end
          ST_DROP: if (i_bus_ok) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_bus_addr = {r_wordAddr, 1'b0};
  assign o_bus_rd   = (r_state == ST_WAIT);

endmodule

// File: doc/jt900h_opfetch.md
Name: jt900h_opfetch

Overview:
- Instruction prefetch queue feeding the decoder.
- Reads 16-bit words from the memory bus into a byte FIFO.
- Presents the next 4 op-code bytes as a little-endian window (op[7:0] = next byte) with a valid flag.
- Retires 0-3 bytes per enabled cycle, as reported by the decoder's fetched count.
- Handles jumps by flushing the queue and restarting at a new byte address, including odd addresses and a bus read already in flight.

Parameters:
QDEPTH, 8, queue capacity in bytes; power of two, at least 6.
AW, 24, address width in bits.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cen  in  1  clock enable; all state changes only when cen=1
pc_load  in  1  flush the queue and restart fetching at pc_new
pc_new  in  AW  new byte address
pc  out  AW  byte address of op[7:0]
op  out  32  next four queued bytes; byte n sits at op[8n+7:8n]
op_ok  out  1  at least 4 valid bytes queued
fetched  in  2  bytes consumed by the decoder this cycle
bus_addr  out  AW  word address; bit 0 always 0
bus_rd  out  1  read request, held until accepted
bus_din  in  16  read data; low byte at the even address
bus_ok  in  1  read data valid; sampled only when cen=1

Behaviour:
- Reset, checked at posedge clk with rst=1: pc=0, bus_addr=0, bus_rd=0, op_ok=0, op=0. Queue count=0, rd/wr pointers=0, skip_lo=0, state=IDLE. Reset overrides an in-flight read; any bus_ok that arrives afterwards is ignored unless state is WAIT.
- State machine: IDLE, WAIT, DROP.
- IDLE:
  - If free space ≥ 2 (count ≤ QDEPTH-2) and pc_load=0: assert bus_rd with the current fetch address, go to WAIT.
  - Otherwise bus_rd=0.
- WAIT (bus_rd=1): on bus_ok, push bus_din and return to IDLE.
  - Push is both bytes, low then high.
  - If skip_lo=1, push only the high byte and clear skip_lo.
  - fetch address += 2.
- DROP (bus_rd=0): entered when pc_load arrives during WAIT. The next bus_ok is discarded, then go to IDLE.
- Queue update per cen cycle: count_next = count + pushed - consumed.
  - consumed = fetched when op_ok=1, otherwise 0.
  - Push and pop in the same cycle are legal.
  - Pointers wrap modulo QDEPTH.
  - pc += consumed.
- op and op_ok are registered. They reflect the queue after the update and are valid the cycle after a push.
  - Latency from bus_ok of the second word after a flush to op_ok=1 is 1 cycle.
- pc_load has priority over everything:
  - count=0 and pointers reset, so op_ok=0 next cycle.
  - pc=pc_new; fetch address = {pc_new[AW-1:1],0}; skip_lo=pc_new[0].
  - fetched in the same cycle is ignored.
  - Push data arriving in the same cycle is discarded.
  - State becomes IDLE if no read was pending, DROP if in WAIT without bus_ok. A simultaneous pc_load and bus_ok counts as consumed, so the next state is IDLE.
  - A new request may start the cycle after pc_load.
- Full queue: no request is issued while free space < 2, so overflow cannot occur.
- fetched larger than the valid count is a decoder error. It cannot happen while op_ok=1, because count ≥ 4 > 3.
- Address wrap: fetch address and pc wrap modulo 2^AW.
- cen=0: all registers hold and bus_ok is ignored. The bus must hold bus_ok until a cen cycle.

Decomposition:
- Shared package jt900h_pkg: state encodings (IDLE/WAIT/DROP) and the AW default. The ctrl FSM constants also live there.
- One natural sub-module, jt900h_opfetch_fifo: byte FIFO with a 2-byte write port, a 4-byte read window, a variable pop of 0-3 bytes, and a count output.
- Top level holds the FSM, the address/pc registers and the flush logic.

Test Plan:
- Reset then pc_load with pc_new=0x000100; memory returns 0x3412 at 0x100 and 0x7856 at 0x102, 1 cycle latency each -> op=0x78563412, op_ok=1, pc=0x000100.
- pc_load with pc_new=0x000101 over the same memory -> first push is only 0x34. op_ok rises once 0x56,0x78 and 0x9A (from 0x104) are queued: op=0x9A785634, pc=0x101.
- Steady state, fetched=1,2,3 on successive cycles with continuous bus_ok -> pc advances 0x100→0x101→0x103→0x106. op shifts to match; the queue never exceeds QDEPTH and no bus_rd is issued while count > 6.
- pc_load to 0x000200 while a read of 0x104 is in WAIT; stale bus_ok with 0xDEAD 2 cycles later -> 0xDEAD is never visible on op. The next bus_addr is 0x000200.
- pc_load and bus_ok in the same cycle -> data discarded, state IDLE. The next cycle issues bus_addr=pc_new aligned.
- cen toggling 1/0 with bus_ok held across cen=0 -> identical op/pc sequence to the cen=1 run, stretched. rst=1 mid-WAIT -> op_ok=0, bus_rd=0 next cycle.
